// File: rtl/fifo_queue.sv
// rtl/fifo_queue.sv - single-clock FIFO queue of WIDTH-bit words, DEPTH entries deep.
// Defining FIFO_ERR_EN adds sticky overflow/underflow outputs.
module fifo_queue #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enqueue,
    input  logic             dequeue,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] q_out,
    output logic             empty,
`ifdef FIFO_ERR_EN
    output logic             overflow,
    output logic             underflow,
`endif
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             wr_accept;
    logic             rd_accept;

    // A pop on a full queue frees the slot the push lands in, so push is allowed.
    assign wr_accept = enqueue & (~full | dequeue);
    assign rd_accept = dequeue & ~empty;

    always_comb begin
        count_next = count;
        if (wr_accept && !rd_accept) begin
            count_next = count + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_next = count - 1'b1;
        end
    end

    // Storage needs no reset; its contents are meaningless until written.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[wr_ptr] <= q_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q_out  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
                q_out  <= mem[rd_ptr];
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == COUNT_MAX);
        end
    end

`ifdef FIFO_ERR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (enqueue && full && !dequeue) begin
                overflow <= 1'b1;
            end
            if (dequeue && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_queue.sv
// tb/tb_fifo_queue.sv - randomized self-checking bench for fifo_queue against a queue model.
module tb_fifo_queue;

    localparam int W = 3;
    localparam int D = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enqueue = 1'b0;
    logic         dequeue = 1'b0;
    logic [W-1:0] q_in = '0;
    logic [W-1:0] q_out;
    logic         empty;
    logic         full;
`ifdef FIFO_ERR_EN
    logic         overflow;
    logic         underflow;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] model_q [$];
    logic [W-1:0] exp_qout = '0;
    logic         exp_ovf = 1'b0;
    logic         exp_unf = 1'b0;

    always #5 clock = ~clock;

    fifo_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .enqueue  (enqueue),
        .dequeue  (dequeue),
        .q_in     (q_in),
        .q_out    (q_out),
        .empty    (empty),
`ifdef FIFO_ERR_EN
        .overflow (overflow),
        .underflow(underflow),
`endif
        .full     (full)
    );

    // Drive one cycle of stimulus and advance the model by the queue's rules.
    task automatic step(input logic enq, input logic deq, input logic [W-1:0] din);
        int n;
        @(negedge clock);
        enqueue = enq;
        dequeue = deq;
        q_in    = din;
        @(posedge clock);
        n = model_q.size();
        if (enq && n == D && !deq) exp_ovf = 1'b1;
        if (deq && n == 0) exp_unf = 1'b1;
        if (deq && n > 0) exp_qout = model_q.pop_front();
        if (enq && (n < D || deq)) model_q.push_back(din);
        #1;
        enqueue = 1'b0;
        dequeue = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        enqueue = 1'b1;
        q_in    = 3'd5;
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0 || q_out !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: empty=%b full=%b q_out=%0d, want 1 0 0", empty, full, q_out);
        end
`ifdef FIFO_ERR_EN
        vectors++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: ovf=%b unf=%b, want 0 0", overflow, underflow);
        end
`endif
        @(negedge clock);
        enqueue = 1'b0;
        reset   = 1'b1;
        step(1'b0, 1'b0, '0);
        vectors++;
        if (empty !== 1'b1 || q_out !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_nowrite: empty=%b q_out=%0d, want 1 0", empty, q_out);
        end
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] seq [8];
        seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, seq[i]);
            vectors++;
            if (empty !== 1'b0 || full !== (i == 7)) begin
                miscompares++;
                $display("FAIL fill_flags[%0d]: empty=%b full=%b, want 0 %b", i, empty, full, i == 7);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, '0);
            vectors++;
            if (q_out !== seq[i] || empty !== (i == 7) || full !== 1'b0) begin
                miscompares++;
                $display("FAIL drain[%0d]: q_out=%0d empty=%b full=%b, want %0d %b 0",
                         i, q_out, empty, full, seq[i], i == 7);
            end
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] v;
        logic [W-1:0] held;
        for (int i = 0; i < D; i++) begin
            v = W'($urandom_range(0, 6));
            if (v == 3'd6) v = 3'd7;
            step(1'b1, 1'b0, v);
        end
        held = exp_qout;
        step(1'b1, 1'b0, 3'd6);
        vectors++;
        if (full !== 1'b1 || q_out !== held) begin
            miscompares++;
            $display("FAIL overflow_hold: full=%b q_out=%0d, want 1 %0d", full, q_out, held);
        end
`ifdef FIFO_ERR_EN
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_flag: got %b want 1", overflow);
        end
`endif
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b1, '0);
            vectors++;
            if (q_out !== exp_qout || q_out === 3'd6) begin
                miscompares++;
                $display("FAIL overflow_drain[%0d]: q_out=%0d want %0d", i, q_out, exp_qout);
            end
        end
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_underflow();
        step(1'b1, 1'b0, 3'd3);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        vectors++;
        if (q_out !== 3'd3 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_hold: q_out=%0d empty=%b, want 3 1", q_out, empty);
        end
`ifdef FIFO_ERR_EN
        vectors++;
        if (underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_flag: got %b want 1", underflow);
        end
`endif
    endtask

    task automatic test_simultaneous();
        step(1'b1, 1'b1, 3'd4);
        vectors++;
        if (empty !== 1'b0 || full !== 1'b0 || q_out !== 3'd3) begin
            miscompares++;
            $display("FAIL simul_empty: empty=%b full=%b q_out=%0d, want 0 0 3", empty, full, q_out);
        end
        for (int i = 1; i < D; i++) step(1'b1, 1'b0, W'($urandom));
        step(1'b1, 1'b1, W'($urandom));
        vectors++;
        if (full !== 1'b1 || q_out !== 3'd4) begin
            miscompares++;
            $display("FAIL simul_full: full=%b q_out=%0d, want 1 4", full, q_out);
        end
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b1, '0);
            vectors++;
            if (q_out !== exp_qout) begin
                miscompares++;
                $display("FAIL simul_drain[%0d]: q_out=%0d want %0d", i, q_out, exp_qout);
            end
        end
    endtask

    task automatic test_wrap_reset();
        int pushes = 0;
        int pops = 0;
        int choice;
        bit can_push;
        bit can_pop;
        while (pushes < 12 || pops < 10) begin
            can_push = (pushes < 12) && (model_q.size() < D);
            can_pop  = (pops < 10) && (model_q.size() > 0);
            choice = $urandom_range(0, 2);
            if (!can_pop) choice = 0;
            else if (!can_push) choice = 1;
            step(choice != 1, choice != 0, W'($urandom));
            if (choice != 1) pushes++;
            if (choice != 0) pops++;
            vectors++;
            if (q_out !== exp_qout || empty !== (model_q.size() == 0) || full !== (model_q.size() == D)) begin
                miscompares++;
                $display("FAIL wrap: q_out=%0d empty=%b full=%b, want %0d %b %b",
                         q_out, empty, full, exp_qout, model_q.size() == 0, model_q.size() == D);
            end
        end
        vectors++;
        if (model_q.size() != 2 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_level: model=%0d empty=%b, want 2 0", model_q.size(), empty);
        end
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0 || q_out !== 3'd0) begin
            miscompares++;
            $display("FAIL async_reset: empty=%b full=%b q_out=%0d, want 1 0 0", empty, full, q_out);
        end
        @(negedge clock);
        reset = 1'b1;
        model_q.delete();
        exp_qout = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        step(1'b0, 1'b1, '0);
        vectors++;
        if (empty !== 1'b1 || q_out !== 3'd0) begin
            miscompares++;
            $display("FAIL post_reset: empty=%b q_out=%0d, want 1 0", empty, q_out);
        end
        step(1'b1, 1'b0, 3'd2);
        step(1'b0, 1'b1, '0);
        vectors++;
        if (q_out !== 3'd2 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_rw: q_out=%0d empty=%b, want 2 1", q_out, empty);
        end
`ifdef FIFO_ERR_EN
        vectors++;
        if (overflow !== exp_ovf || underflow !== exp_unf) begin
            miscompares++;
            $display("FAIL post_reset_err: ovf=%b unf=%b, want %b %b", overflow, underflow, exp_ovf, exp_unf);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule
